// File: rtl/dmac_pkg.sv
// Shared defaults and helpers for the DMA channel arbiter.
// Kept tiny so every DMAC block can import it without pulling in logic.
package dmac_pkg;

  localparam int DMAC_NCH   = 4;
  localparam int DMAC_DW    = 32;
  localparam int DMAC_DEPTH = 16;
  localparam int DMAC_CHW   = 4;

  // Ceiling log2; used for pointer widths (DEPTH is a power of two).
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmac_fifo_p.sv
// Per-channel FIFO with synchronous flush, occupancy count and sticky overflow.
// A write to a full FIFO is accepted only if the head is popped in the same cycle.
module dmac_fifo_p
  import dmac_pkg::*;
#(
  parameter  int DW    = DMAC_DW,
  parameter  int DEPTH = DMAC_DEPTH,
  localparam int AW    = log2c(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          w_pop;
  logic          w_push;

  assign empty = (r_level == '0);
  assign full  = (r_level == FULL_LVL);
  assign level = r_level;
  assign ovf   = r_ovf;
  assign rdata = r_mem[r_rptr];

  // A flush wins over both ports; a pop frees the slot a full-FIFO write needs.
  assign w_pop  = rd && !clr && !empty;
  assign w_push = wr && !clr && (!full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (wr && !w_push) r_ovf <= 1'b1;
    end
  end

  // Storage has no reset: contents are meaningless while level is 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/dmac_chan_arb.sv
// NCH channel FIFOs drained round-robin into a single ready/valid output register.
// Arbiter and output register live here; storage is in dmac_fifo_p.
module dmac_chan_arb
  import dmac_pkg::*;
#(
  parameter  int NCH   = DMAC_NCH,
  parameter  int DW    = DMAC_DW,
  parameter  int DEPTH = DMAC_DEPTH,
  localparam int AW    = log2c(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        clr,
  input  logic [NCH-1:0]        wr,
  input  logic [NCH*DW-1:0]     wdata,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        empty,
  output logic [NCH*(AW+1)-1:0] level,
  output logic [NCH-1:0]        ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [3:0]            out_chan
);

  logic [NCH-1:0][DW-1:0] w_head;
  logic [NCH-1:0]         w_pop;
  logic [NCH-1:0]         w_elig;
  logic [NCH-1:0]         w_hi_oh;
  logic [NCH-1:0]         w_lo_oh;
  logic [NCH-1:0]         w_gnt_oh;
  logic                   w_hi_vld;
  logic                   w_gnt_vld;
  logic [3:0]             w_gnt;
  logic [DW-1:0]          w_sel_data;
  logic                   w_load_en;

  logic                   r_out_valid;
  logic [DW-1:0]          r_out_data;
  logic [3:0]             r_out_chan;
  logic [3:0]             r_last;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    dmac_fifo_p #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr[g]),
      .wr    (wr[g]),
      .wdata (wdata[g*DW +: DW]),
      .rd    (w_pop[g]),
      .rdata (w_head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .level (level[g*(AW+1) +: AW+1]),
      .ovf   (ovf[g])
    );
  end

  assign w_load_en = !r_out_valid || out_ready;
  // Empty is registered state, so a same-cycle write never makes a channel eligible.
  assign w_elig    = ~empty & ~clr;
  assign w_pop     = w_load_en ? w_gnt_oh : '0;

  // Round-robin: first eligible above last grant, else wrap to lowest eligible.
  always_comb begin
    w_hi_oh   = '0;
    w_lo_oh   = '0;
    w_hi_vld  = 1'b0;
    w_gnt_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_elig[i] && !w_gnt_vld) begin
        w_lo_oh[i] = 1'b1;
        w_gnt_vld  = 1'b1;
      end
      if (w_elig[i] && (4'(i) > r_last) && !w_hi_vld) begin
        w_hi_oh[i] = 1'b1;
        w_hi_vld   = 1'b1;
      end
    end
    w_gnt_oh = w_hi_vld ? w_hi_oh : w_lo_oh;
  end

  always_comb begin
    w_gnt      = '0;
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt_oh[i]) begin
        w_gnt      = w_gnt | 4'(i);
        w_sel_data = w_sel_data | w_head[i];
      end
    end
  end

  // Output register is independent of the FIFOs: a flush never touches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_last      <= 4'(NCH-1);
    end else if (w_load_en) begin
      r_out_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_out_data <= w_sel_data;
        r_out_chan <= w_gnt;
        r_last     <= w_gnt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: doc/dmac_chan_arb.md
DMAC_CHAN_ARB -- requirements
Module: dmac_chan_arb

Interface
REQ-001 SHALL have parameter NCH, default 4, number of channels (2..16).
REQ-002 SHALL have parameter DW, default 32, data width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, entries per channel FIFO (power of 2, >=2); localparam AW = log2(DEPTH).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clr, input, NCH, per-channel synchronous flush.
REQ-007 SHALL have port wr, input, NCH, per-channel write strobe.
REQ-008 SHALL have port wdata, input, NCH*DW, channel i data at bits [i*DW +: DW].
REQ-009 SHALL have port full, output, NCH, channel FIFO full.
REQ-010 SHALL have port empty, output, NCH, channel FIFO empty.
REQ-011 SHALL have port level, output, NCH*(AW+1), channel occupancy 0..DEPTH.
REQ-012 SHALL have port ovf, output, NCH, sticky write-when-full flag.
REQ-013 SHALL have port out_valid, output, 1, output register holds a word.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts word.
REQ-015 SHALL have port out_data, output, DW, drained word.
REQ-016 SHALL have port out_chan, output, 4, source channel index of out_data.

Function
REQ-017 SHALL accept a write to channel i when wr[i]=1, clr[i]=0 and (full[i]=0 or channel i popped this cycle).
REQ-018 SHALL drop a write to a full, non-popped channel, leave contents unchanged, and set ovf[i].
REQ-019 SHALL, on clr[i]=1, empty channel i and clear ovf[i] next cycle; a same-cycle wr[i] or pop of channel i is discarded.
REQ-020 SHALL not disturb a word already in the output register when its source channel is cleared.
REQ-021 SHALL define load_en = !out_valid or out_ready.
REQ-022 SHALL, when load_en=1 and any channel (not being cleared) is non-empty, grant exactly one such channel, pop its head, and present it on out_data/out_chan with out_valid=1 on the next cycle (1-cycle latency).
REQ-023 SHALL deassert out_valid next cycle when load_en=1 and no channel is eligible.
REQ-024 SHALL hold out_data, out_chan, out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain one word per cycle when out_ready is held high.
REQ-026 SHALL arbitrate round-robin: grant the first eligible channel cyclically after last_grant; last_grant updates only on grant.
REQ-027 SHALL not grant a channel whose empty=1 at the start of the cycle (same-cycle write is not bypassed).
REQ-028 SHALL update level as +1 write, -1 pop, unchanged for both; full = (level==DEPTH), empty = (level==0).
REQ-029 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-030 SHALL, on rst=0, asynchronously set all FIFOs empty, level=0, full=0, empty=all ones, ovf=0, out_valid=0, out_data=0, out_chan=0, last_grant=NCH-1.
REQ-031 SHALL lose all buffered data on reset mid-operation; first grant after reset goes to lowest-indexed non-empty channel.

Structure
REQ-032 SHALL place default NCH/DW/DEPTH constants and the log2 helper in shared package dmac_pkg.
REQ-033 SHALL instantiate NCH copies of sub-module dmac_fifo_p (parametrised DW/DEPTH FIFO with clear, level, full, empty) via generate loop.
REQ-034 SHALL implement arbiter and output register in dmac_chan_arb itself.

Verification
REQ-035 SHALL test: 16 writes to ch0 then 17th write -> full[0]=1, level=16, ovf[0]=1, stored data unchanged.
REQ-036 SHALL test: ch0..3 each hold 2 words, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3 at one word per cycle.
REQ-037 SHALL test: out_ready=0 for 5 cycles with valid word 0xA5A5A5A5 -> out_data/out_chan held, no further pops.
REQ-038 SHALL test: wr[2] and clr[2] same cycle on level 3 -> level[2]=0, empty[2]=1, ovf[2]=0 next cycle.
REQ-039 SHALL test: full ch1 with simultaneous write and grant -> write accepted, level stays 16, ovf[1]=0.
REQ-040 SHALL test: rst=0 asserted mid-stream -> all outputs at REQ-030 values immediately, without waiting for a clock edge.
